// File: rtl/axil_ram_v2.sv
// AXI4-Lite slave RAM with independent AW/W capture, byte strobes, optional
// read-only boot region and SLVERR on out-of-window or protected accesses.
module axil_ram_v2 #(
    parameter int unsigned OFFSET       = 32'd0,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int          MEMORY_DEPTH = 119808,
    parameter int          RO_WORDS     = 0,
    parameter string       INIT_FILE    = ""
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] OFF_EXT   = (ADDR_WIDTH+1)'(OFFSET);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [ADDR_WIDTH:0] RO_EXT    = (ADDR_WIDTH+1)'(RO_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Decode is done one bit wider than the bus so a low address cannot wrap into range.
    function automatic logic [ADDR_WIDTH:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - OFF_EXT;
        return diff >> BYTE_SHIFT;
    endfunction

    function automatic logic above_base(input logic [ADDR_WIDTH-1:0] addr);
        return (OFFSET == 32'd0) || ({1'b0, addr} >= OFF_EXT);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic                  run_r, awready_r, wready_r, aw_full_r, w_full_r;
    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0] wdata_r, rdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;
    logic                  bvalid_r, rvalid_r;
    logic [1:0]            bresp_r, rresp_r;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, arready_s, commit_s;
    logic                  aw_full_nx_s, w_full_nx_s, wr_ok_s, rd_ok_s;
    logic [ADDR_WIDTH:0]   aw_idx_s, ar_idx_s;
    logic                  unused_s;

    assign aw_idx_s  = word_index(awaddr_r);
    assign ar_idx_s  = word_index(s_axil_araddr);
    assign wr_ok_s   = above_base(awaddr_r) && (aw_idx_s < DEPTH_EXT)
                       && ((RO_WORDS == 0) || (aw_idx_s >= RO_EXT));
    assign rd_ok_s   = above_base(s_axil_araddr) && (ar_idx_s < DEPTH_EXT);
    assign aw_hs_s   = s_axil_awvalid && awready_r;
    assign w_hs_s    = s_axil_wvalid && wready_r;
    assign arready_s = run_r && (!rvalid_r || s_axil_rready);
    assign ar_hs_s   = s_axil_arvalid && arready_s;
    assign commit_s  = aw_full_r && w_full_r && (!bvalid_r || s_axil_bready);
    assign unused_s  = ^{s_axil_awprot, s_axil_arprot};

    // Next occupancy of the AW and W holding registers.
    always_comb begin
        aw_full_nx_s = aw_full_r;
        w_full_nx_s  = w_full_r;
        if (commit_s) begin
            aw_full_nx_s = 1'b0;
            w_full_nx_s  = 1'b0;
        end else begin
            if (aw_hs_s) aw_full_nx_s = 1'b1;
            else         aw_full_nx_s = aw_full_r;
            if (w_hs_s)  w_full_nx_s  = 1'b1;
            else         w_full_nx_s  = w_full_r;
        end
    end

    // Control and response state; ready outputs are registered copies of !full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_r     <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            run_r     <= 1'b1;
            aw_full_r <= aw_full_nx_s;
            w_full_r  <= w_full_nx_s;
            awready_r <= !aw_full_nx_s;
            wready_r  <= !w_full_nx_s;
            if (aw_hs_s) awaddr_r <= s_axil_awaddr;
            if (w_hs_s) begin
                wdata_r <= s_axil_wdata;
                wstrb_r <= s_axil_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bready) begin
                bvalid_r <= 1'b0;
            end
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_ok_s ? mem[ar_idx_s[IDX_W-1:0]] : '0;
                rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Byte-lane RAM update; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (commit_s && wr_ok_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb_r[i]) mem[aw_idx_s[IDX_W-1:0]][i*8 +: 8] <= wdata_r[i*8 +: 8];
            end
        end
    end

    assign s_axil_awready = awready_r;
    assign s_axil_wready  = wready_r;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_arready = arready_s;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rdata   = rdata_r;
    assign s_axil_rresp   = rresp_r;
endmodule

// File: tb/tb_axil_ram_v2.sv
// Scoreboard bench for axil_ram_v2: expected responses are queued at issue time
// from an array model and compared by an independent monitor.
module tb_axil_ram_v2;
    localparam logic [31:0] OFF   = 32'h1000;
    localparam int          DEPTH = 256;
    localparam int          RO    = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 manual readies, 1 random, 2 toggling rready

    logic [31:0] model_mem [DEPTH];
    logic [1:0]  exp_b[$];
    logic [31:0] exp_rdata[$];
    logic [1:0]  exp_rresp[$];

    always #5 clk = ~clk;

    axil_ram_v2 #(.OFFSET(32'h1000), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(256),
                  .RO_WORDS(16)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        errors++;
        $display("FAIL %s: got timeout expected handshake at %0t", nm, $time);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= longint'(OFF)) && ((la - longint'(OFF)) / 4 < DEPTH);
    endfunction

    // Reference: push the expected B response and apply legal writes to the array.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (in_window(a) && ((longint'(a) - longint'(OFF)) / 4 >= RO)) begin
            idx = int'((longint'(a) - longint'(OFF)) / 4);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        if (in_window(a)) begin
            exp_rdata.push_back(model_mem[int'((longint'(a) - longint'(OFF)) / 4)]);
            exp_rresp.push_back(2'b00);
        end else begin
            exp_rdata.push_back(32'h0);
            exp_rresp.push_back(2'b10);
        end
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead);
        model_write(a, d, s);
        fork
            begin
                int t = 0;
                repeat ((lead > 0) ? lead : 0) @(posedge clk);
                #1; awaddr = a; awvalid = 1'b1;
                do begin @(negedge clk); t++; end while (!awready && t < 100);
                if (!awready) timeout("aw_handshake");
                @(posedge clk); #1; awvalid = 1'b0;
            end
            begin
                int t = 0;
                repeat ((lead < 0) ? -lead : 0) @(posedge clk);
                #1; wdata = d; wstrb = s; wvalid = 1'b1;
                do begin @(negedge clk); t++; end while (!wready && t < 100);
                if (!wready) timeout("w_handshake");
                @(posedge clk); #1; wvalid = 1'b0;
            end
        join
    endtask

    task automatic do_reads(input logic [31:0] addrs[$]);
        foreach (addrs[k]) begin
            int t = 0;
            bit hs = 1'b0;
            model_read(addrs[k]);
            araddr = addrs[k]; arvalid = 1'b1;
            while (!hs && t < 100) begin
                @(negedge clk); t++;
                chk("arready_rule", {63'd0, arready}, {63'd0, (!rvalid || rready)});
                hs = arready;
            end
            if (!hs) timeout("ar_handshake");
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_b.size() != 0 || exp_rdata.size() != 0) && t < 400) begin
            @(posedge clk); t++;
        end
        if (exp_b.size() != 0 || exp_rdata.size() != 0) timeout("drain");
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every B/R handshake and checks hold stability.
    bit          b_stall = 1'b0, r_stall = 1'b0;
    logic [1:0]  b_prev_resp, r_prev_resp;
    logic [31:0] r_prev_data;
    always @(negedge clk) begin
        if (aresetn) begin
            if (b_stall) begin
                chk("b_hold_valid", {63'd0, bvalid}, 64'd1);
                chk("b_hold_resp", {62'd0, bresp}, {62'd0, b_prev_resp});
            end
            if (r_stall) begin
                chk("r_hold_valid", {63'd0, rvalid}, 64'd1);
                chk("r_hold_data", {32'd0, rdata}, {32'd0, r_prev_data});
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) timeout("b_unexpected");
                else chk("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_rdata.size() == 0) timeout("r_unexpected");
                else begin
                    chk("rdata", {32'd0, rdata}, {32'd0, exp_rdata.pop_front()});
                    chk("rresp", {62'd0, rresp}, {62'd0, exp_rresp.pop_front()});
                end
            end
            b_stall = bvalid && !bready;
            r_stall = rvalid && !rready;
        end else begin
            b_stall = 1'b0;
            r_stall = 1'b0;
        end
        b_prev_resp = bresp;
        r_prev_resp = rresp;
        r_prev_data = rdata;
    end

    // Background ready generator for the random and toggling phases.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mode == 1) begin
                bready = 1'($urandom_range(0, 1));
                rready = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                rready = !rready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] aq[$];
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
        awprot = 3'd0; arprot = 3'd0; bready = 1'b1; rready = 1'b1;
        #1;
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1; aresetn = 1'b1;
        chk("rel_awready0", {63'd0, awready}, 64'd0);
        @(posedge clk); #1;
        chk("rel_awready1", {63'd0, awready}, 64'd1);
        chk("rel_wready1", {63'd0, wready}, 64'd1);
        chk("rel_arready1", {63'd0, arready}, 64'd1);

        // 1: AW+W same cycle, timing of B and R
        model_write(32'h1040, 32'h11223344, 4'hF);
        awaddr = 32'h1040; wdata = 32'h11223344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_bvalid_c1", {63'd0, bvalid}, 64'd0);
        chk("t1_awready_c1", {63'd0, awready}, 64'd0);
        @(posedge clk); #1;
        chk("t1_bvalid_c2", {63'd0, bvalid}, 64'd1);
        @(posedge clk); #1;
        model_read(32'h1040);
        araddr = 32'h1040; arvalid = 1'b1;
        @(posedge clk); #1; arvalid = 1'b0;
        chk("t1_rvalid_lat", {63'd0, rvalid}, 64'd1);
        drain();

        // 2: W three cycles ahead of AW, partial strobe
        fork
            do_write(32'h1044, 32'hAABBCCDD, 4'h5, 3);
            begin
                @(posedge clk); #1;
                chk("t2_wready_drop", {63'd0, wready}, 64'd0);
                @(posedge clk); #1;
                chk("t2_wready_hold", {63'd0, wready}, 64'd0);
            end
        join
        drain();
        aq = {32'h1044};
        do_reads(aq);
        drain();

        // 3: protected and out-of-window accesses
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0);
        do_write(32'h1400, 32'hFFFFFFFF, 4'hF, -2);
        drain();
        aq = {32'h1000, 32'h0FFC, 32'h13FC, 32'h1400, 32'h1003};
        do_reads(aq);
        drain();

        // 4: B backpressure holds a second captured write
        bready = 1'b0;
        do_write(32'h1050, 32'h5A5A5A5A, 4'hF, 0);
        @(posedge clk); #1;
        do_write(32'h1004, 32'h12345678, 4'hF, 0);
        repeat (5) begin
            chk("t4_bvalid", {63'd0, bvalid}, 64'd1);
            chk("t4_awready", {63'd0, awready}, 64'd0);
            chk("t4_wready", {63'd0, wready}, 64'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        chk("t4_bvalid_rel", {63'd0, bvalid}, 64'd1);
        chk("t4_bresp_new", {62'd0, bresp}, 64'd2);
        chk("t4_awready_rel", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        chk("t4_bvalid_clr", {63'd0, bvalid}, 64'd0);
        drain();

        // 5: back-to-back reads with alternating rready
        do_write(32'h1048, 32'hCAFEF00D, 4'hF, 1);
        drain();
        rready = 1'b1; mode = 2;
        aq = {32'h1040, 32'h1044, 32'h1048, 32'h1050};
        do_reads(aq);
        mode = 0;
        @(posedge clk); #1; rready = 1'b1;
        drain();

        // 6: reset with only AW captured
        awaddr = 32'h1048; awvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0;
        chk("t6_awfull", {63'd0, awready}, 64'd0);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("t6_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("t6_rst_arready", {63'd0, arready}, 64'd0);
        chk("t6_rst_wready", {63'd0, wready}, 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        chk("t6_rel_awready0", {63'd0, awready}, 64'd0);
        @(posedge clk); #1;
        chk("t6_rel_awready1", {63'd0, awready}, 64'd1);
        chk("t6_rel_wready1", {63'd0, wready}, 64'd1);
        aq = {32'h1048};
        do_reads(aq);
        drain();

        // Random phase: writes with random ordering/backpressure, then reads
        mode = 1;
        for (int n = 0; n < 60; n++)
            do_write(32'h0FE0 + 32'($urandom_range(0, 32'h440)), $urandom,
                     4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
        drain();
        aq = {};
        for (int n = 0; n < 60; n++) aq.push_back(32'h0FE0 + 32'($urandom_range(0, 32'h440)));
        do_reads(aq);
        drain();
        mode = 0;
        @(posedge clk); #1; bready = 1'b1; rready = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
